// File: rtl/dma_pkg.sv
// dma_pkg
//   Shared definitions for the DMA path: word and address widths, the
//   cherry-float word type and the burst controller state encoding.
//   Used by dma_burst_ctrl, dma_uart and the DMA read-path blocks.
//   No ports (package).

package dma_pkg;

    localparam int DAT_W        = 18;
    localparam int DMA_ADDR_W   = 7;
    localparam int CACHE_ADDR_W = 10;
    localparam int LEN_W        = 8;

    // Cycles ARM waits for dma_uart to raise busy before the word is
    // considered consumed anyway.
    localparam int ARM_TIMEOUT  = 2;

    typedef logic [DAT_W-1:0] cherry_float_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_ARM   = 3'd4,
        ST_DRAIN = 3'd5
    } dma_burst_state_e;

endpackage

// File: rtl/dma_burst_ctrl.sv
// dma_burst_ctrl
//   Burst feeder for dma_uart. Takes one request (start cache address,
//   start DMA address, word count), reads each word from the cache read
//   port and hands it to dma_uart as a single-word write, pacing itself
//   on dma_uart's busy flag. Addresses wrap modulo their width.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-low
//   req_valid      in   burst request present
//   req_ready      out  high only while idle
//   req_cache_addr in   first cache word address
//   req_dma_addr   in   first DMA word address
//   req_len        in   number of words (0 = empty burst)
//   cache_re       out  cache read strobe
//   cache_raddr    out  cache read address
//   cache_rdata    in   read data, valid one cycle after cache_re
//   dma_dat_w      out  word to dma_uart
//   dma_dat_addr   out  address to dma_uart
//   we             out  one-cycle write pulse to dma_uart
//   busy           in   dma_uart busy
//   done           out  one-cycle pulse in the first idle cycle after a burst
//   state_dbg      out  current FSM state (dma_burst_state_e encoding)
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; the source holds the request stable until then.
// req_valid is ignored whenever req_ready is low.

module dma_burst_ctrl
    import dma_pkg::*;
#(
    parameter int DAT_W        = dma_pkg::DAT_W,
    parameter int DMA_ADDR_W   = dma_pkg::DMA_ADDR_W,
    parameter int CACHE_ADDR_W = dma_pkg::CACHE_ADDR_W,
    parameter int LEN_W        = dma_pkg::LEN_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [CACHE_ADDR_W-1:0] req_cache_addr,
    input  logic [DMA_ADDR_W-1:0]   req_dma_addr,
    input  logic [LEN_W-1:0]        req_len,
    output logic                    cache_re,
    output logic [CACHE_ADDR_W-1:0] cache_raddr,
    input  logic [DAT_W-1:0]        cache_rdata,
    output logic [DAT_W-1:0]        dma_dat_w,
    output logic [DMA_ADDR_W-1:0]   dma_dat_addr,
    output logic                    we,
    input  logic                    busy,
    output logic                    done,
    output logic [2:0]              state_dbg
);

    dma_burst_state_e state_q, state_d;

    logic [CACHE_ADDR_W-1:0] cur_cache_q;
    logic [DMA_ADDR_W-1:0]   cur_dma_q;
    logic [LEN_W-1:0]        remaining_q;
    logic [1:0]              arm_cnt_q;
    logic [DAT_W-1:0]        dat_q;
    logic [DMA_ADDR_W-1:0]   addr_q;
    logic                    done_q;

    logic accept;
    logic word_done;
    logic last_word;

    assign last_word = (remaining_q == LEN_W'(1));

    // Next-state and strobes.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        word_done = 1'b0;
        cache_re  = 1'b0;
        we        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    // An empty burst only produces done; no fetch.
                    if (req_len != '0) begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                cache_re = 1'b1;
                state_d  = ST_LOAD;
            end
            ST_LOAD: begin
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!busy) begin
                    we      = 1'b1;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                // dma_uart normally answers the write with busy on the next
                // cycle; if it never does, the word is taken as consumed.
                if (busy || (arm_cnt_q == 2'(ARM_TIMEOUT - 1))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!busy) begin
                    word_done = 1'b1;
                    state_d   = last_word ? ST_IDLE : ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_cache_q <= '0;
            cur_dma_q   <= '0;
            remaining_q <= '0;
            arm_cnt_q   <= '0;
            dat_q       <= '0;
            addr_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            // done lands in the first idle cycle, whether the burst was
            // empty or just finished its last word.
            done_q <= (accept && (req_len == '0)) || (word_done && last_word);

            if (accept) begin
                cur_cache_q <= req_cache_addr;
                cur_dma_q   <= req_dma_addr;
                remaining_q <= req_len;
            end

            if (state_q == ST_LOAD) begin
                dat_q  <= cache_rdata;
                addr_q <= cur_dma_q;
            end

            if (word_done) begin
                remaining_q <= remaining_q - LEN_W'(1);
                cur_cache_q <= cur_cache_q + CACHE_ADDR_W'(1);
                cur_dma_q   <= cur_dma_q + DMA_ADDR_W'(1);
            end

            if (state_q == ST_ARM) begin
                arm_cnt_q <= arm_cnt_q + 2'd1;
            end else begin
                arm_cnt_q <= '0;
            end
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign cache_raddr  = cur_cache_q;
    assign dma_dat_w    = dat_q;
    assign dma_dat_addr = addr_q;
    assign done         = done_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_dma_burst_ctrl.sv
// tb_dma_burst_ctrl
//   Bench for dma_burst_ctrl with a cache model (1-cycle read latency)
//   and a dma_uart busy stub (busy rises the cycle after we, 40 cycles).

module tb_dma_burst_ctrl;
    import dma_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset = 1'b0;

    // ---------------- DUT signals ----------------
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [9:0]  req_cache_addr = '0;
    logic [6:0]  req_dma_addr = '0;
    logic [7:0]  req_len = '0;
    logic        cache_re;
    logic [9:0]  cache_raddr;
    logic [17:0] cache_rdata = '0;
    logic [17:0] dma_dat_w;
    logic [6:0]  dma_dat_addr;
    logic        we;
    logic        busy;
    logic        done;
    logic [2:0]  state_dbg;

    dma_burst_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_cache_addr (req_cache_addr),
        .req_dma_addr   (req_dma_addr),
        .req_len        (req_len),
        .cache_re       (cache_re),
        .cache_raddr    (cache_raddr),
        .cache_rdata    (cache_rdata),
        .dma_dat_w      (dma_dat_w),
        .dma_dat_addr   (dma_dat_addr),
        .we             (we),
        .busy           (busy),
        .done           (done),
        .state_dbg      (state_dbg)
    );

    // ---------------- environment models ----------------
    logic [17:0] mem [1024];
    always @(posedge clk) begin
        if (cache_re) cache_rdata <= mem[cache_raddr];
    end

    int   busy_cnt = 0;
    bit   stub_en = 1'b1;
    logic ext_busy = 1'b0;
    always @(posedge clk) begin
        if (stub_en && we) busy_cnt <= 40;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign busy = (busy_cnt != 0) | ext_busy;

    // ---------------- scoreboard ----------------
    logic [9:0]  rd_q[$];
    logic [24:0] exp_q[$];
    int done_exp = 0;
    int total = 0;
    int bad = 0;
    int we_cnt = 0;
    int cyc = 0;
    int fetch_cyc = 0;
    bit stalled = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a burst is just n consecutive words with both
    // addresses wrapping modulo their range.
    task automatic model_push(input int c, input int d, input int n);
        for (int i = 0; i < n; i++) begin
            int ca;
            int da;
            ca = (c + i) % 1024;
            da = (d + i) % 128;
            rd_q.push_back(10'(ca));
            exp_q.push_back({7'(da), mem[ca]});
        end
        done_exp++;
    endtask

    // Monitor
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            if (cache_re) begin
                if (rd_q.size() == 0) chk("unexpected cache_re", 1, 0);
                else chk("cache_raddr", 32'(cache_raddr), 32'(rd_q.pop_front()));
                fetch_cyc = cyc;
                stalled = 1'b0;
            end else if (busy) begin
                stalled = 1'b1;
            end
            if (we) begin
                we_cnt++;
                chk("we while busy", 32'(busy), 0);
                if (exp_q.size() == 0) chk("unexpected we", 1, 0);
                else chk("write addr/data", 32'({dma_dat_addr, dma_dat_w}), 32'(exp_q.pop_front()));
                if (!stalled) chk("fetch to we latency", 32'(cyc - fetch_cyc), 2);
            end
            if (done) begin
                chk("done in idle", 32'(req_ready), 1);
                if (done_exp == 0) chk("unexpected done", 1, 0);
                else done_exp--;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_req(input int c, input int d, input int n, input bit done_at_accept);
        int w;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_cache_addr = 10'(c);
        req_dma_addr = 7'(d);
        req_len = 8'(n);
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            chk("request accept timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        if (done_at_accept) chk("accept in done cycle", 32'(done), 1);
        model_push(c, d, n);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (n == 0) begin
            @(negedge clk);
            chk("len0 done latency", 32'(done), 1);
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge clk);
        while (!(rd_q.size() == 0 && exp_q.size() == 0 && done_exp == 0 && req_ready) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        chk("burst completion", 32'(w < 5000), 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int w;
        for (int i = 0; i < 1024; i++) mem[i] = 18'($urandom);

        repeat (3) @(negedge clk);
        chk("reset cache_re", 32'(cache_re), 0);
        chk("reset cache_raddr", 32'(cache_raddr), 0);
        chk("reset dma_dat_w", 32'(dma_dat_w), 0);
        chk("reset dma_dat_addr", 32'(dma_dat_addr), 0);
        chk("reset we", 32'(we), 0);
        chk("reset done", 32'(done), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("req_ready after reset", 32'(req_ready), 1);

        // single word
        mem[5] = 18'h3A5D5;
        do_req(5, 'h19, 1, 1'b0);
        wait_idle();
        chk("single word data held", 32'(dma_dat_w), 32'h3A5D5);
        chk("single word addr held", 32'(dma_dat_addr), 32'h19);

        // four words
        base = we_cnt;
        do_req('h100, 'h10, 4, 1'b0);
        wait_idle();
        chk("four word we count", 32'(we_cnt - base), 4);

        // wrap of both address spaces
        do_req('h3FF, 'h7E, 3, 1'b0);
        wait_idle();

        // held request accepted in the done cycle, then empty bursts
        do_req('h20, 'h30, 2, 1'b0);
        do_req('h40, 'h50, 0, 1'b1);
        wait_idle();
        base = we_cnt;
        do_req(7, 7, 0, 1'b0);
        wait_idle();
        chk("len0 no we", 32'(we_cnt - base), 0);

        // dma_uart never answers: ARM times out and the burst still ends
        stub_en = 1'b0;
        do_req('h300, 'h05, 3, 1'b0);
        wait_idle();
        stub_en = 1'b1;

        // busy already high at accept
        ext_busy = 1'b1;
        base = we_cnt;
        do_req('h50, 'h60, 2, 1'b0);
        repeat (10) @(negedge clk);
        chk("stall in issue", 32'(we_cnt - base), 0);
        ext_busy = 1'b0;
        wait_idle();

        // randomized bursts
        for (int k = 0; k < 25; k++) begin
            bit hold_busy;
            stub_en = ($urandom_range(0, 3) != 0);
            hold_busy = ($urandom_range(0, 3) == 0);
            if (hold_busy) ext_busy = 1'b1;
            do_req($urandom_range(0, 1023), $urandom_range(0, 127), $urandom_range(0, 5), 1'b0);
            if (hold_busy) begin
                repeat ($urandom_range(2, 15)) @(negedge clk);
                ext_busy = 1'b0;
            end
            wait_idle();
        end
        stub_en = 1'b1;

        // reset during DRAIN of word 2 of 4
        base = we_cnt;
        do_req('h200, 'h40, 4, 1'b0);
        w = 0;
        while (!((we_cnt - base) == 2 && state_dbg == 3'(ST_DRAIN)) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk("reach drain of word 2", 32'(w < 3000), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid reset cache_re", 32'(cache_re), 0);
        chk("mid reset cache_raddr", 32'(cache_raddr), 0);
        chk("mid reset dma_dat_w", 32'(dma_dat_w), 0);
        chk("mid reset dma_dat_addr", 32'(dma_dat_addr), 0);
        chk("mid reset we", 32'(we), 0);
        chk("mid reset done", 32'(done), 0);
        rd_q.delete();
        exp_q.delete();
        done_exp = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("req_ready after mid reset", 32'(req_ready), 1);
        do_req('h10, 'h11, 1, 1'b0);
        wait_idle();

        repeat (5) @(negedge clk);
        chk("leftover expected items", 32'(rd_q.size() + exp_q.size() + done_exp), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
